// File: rtl/mem_copy_initiator.sv
// Word-by-word memory copy engine: read src, write dst, one outstanding request, 4 cycles/word at zero stall.
// Put/get enables are decoded from state only; stalls on put_ready / get_ready simply hold the current state.
module mem_copy_initiator #(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] len_words,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [LEN_WIDTH-1:0] words_done,
  output logic                 mem_put_enable,
  input  logic                 mem_put_ready,
  output logic [67:0]          mem_put_request,
  output logic                 mem_get_enable,
  input  logic                 mem_get_ready,
  input  logic [67:0]          mem_get_response
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_REQ = 3'd1,
    S_RD_RSP = 3'd2,
    S_WR_REQ = 3'd3,
    S_WR_RSP = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [31:0]          r_src;
  logic [31:0]          r_dst;
  logic [31:0]          r_rd_data;
  logic [LEN_WIDTH-1:0] r_rem;
  logic [LEN_WIDTH-1:0] r_words_done;
  logic                 r_error;

  logic [3:0]           w_rsp_be;
  logic [31:0]          w_rsp_addr;
  logic [31:0]          w_rsp_data;
  logic                 w_rd_ok;
  logic                 w_wr_ok;
  logic                 w_last;
  logic                 w_len_zero;

  assign w_rsp_be   = mem_get_response[67:64];
  assign w_rsp_addr = mem_get_response[63:32];
  assign w_rsp_data = mem_get_response[31:0];
  assign w_rd_ok    = (w_rsp_be == 4'b0000) && (w_rsp_addr == r_src);
  assign w_wr_ok    = (w_rsp_be == 4'b1111) && (w_rsp_addr == r_dst);
  assign w_last     = (r_rem == LEN_WIDTH'(1));
  assign w_len_zero = (len_words == '0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = w_len_zero ? S_DONE : S_RD_REQ;
      S_RD_REQ: if (mem_put_ready) w_next = S_RD_RSP;
      S_RD_RSP: if (mem_get_ready) w_next = w_rd_ok ? S_WR_REQ : S_DONE;
      S_WR_REQ: if (mem_put_ready) w_next = S_WR_RSP;
      S_WR_RSP: if (mem_get_ready) w_next = (!w_wr_ok || w_last) ? S_DONE : S_RD_REQ;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_put_enable  = 1'b0;
    mem_get_enable  = 1'b0;
    mem_put_request = 68'h0;
    busy            = 1'b0;
    done            = 1'b0;
    case (r_state)
      S_RD_REQ: begin
        mem_put_enable  = 1'b1;
        mem_put_request = {4'b0000, r_src, 32'h0};
        busy            = 1'b1;
      end
      S_RD_RSP: begin
        mem_get_enable = 1'b1;
        busy           = 1'b1;
      end
      S_WR_REQ: begin
        mem_put_enable  = 1'b1;
        mem_put_request = {4'b1111, r_dst, r_rd_data};
        busy            = 1'b1;
      end
      S_WR_RSP: begin
        mem_get_enable = 1'b1;
        busy           = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Address/count registers only move on accepted responses, so the request stays stable under stall.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_src        <= 32'h0;
      r_dst        <= 32'h0;
      r_rd_data    <= 32'h0;
      r_rem        <= '0;
      r_words_done <= '0;
      r_error      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_error      <= 1'b0;
            r_words_done <= '0;
            if (!w_len_zero) begin
              r_src <= {src_addr[31:2], 2'b00};
              r_dst <= {dst_addr[31:2], 2'b00};
              r_rem <= len_words;
            end
          end
        end
        S_RD_RSP: begin
          if (mem_get_ready) begin
            r_rd_data <= w_rsp_data;
            if (!w_rd_ok) r_error <= 1'b1;
          end
        end
        S_WR_RSP: begin
          if (mem_get_ready) begin
            if (!w_wr_ok) begin
              r_error <= 1'b1;
            end else begin
              r_words_done <= r_words_done + LEN_WIDTH'(1);
              r_rem        <= r_rem - LEN_WIDTH'(1);
              if (!w_last) begin
                r_src <= r_src + 32'd4;
                r_dst <= r_dst + 32'd4;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign error      = r_error;
  assign words_done = r_words_done;

endmodule
